// File: rtl/data_sram_responder.sv
// SRAM-like data port responder: registered 1-cycle reads, byte-lane writes,
// array clear after reset, and saturating read/write counters for debug.
module data_sram_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter bit INIT_EN    = 1'b1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 data_sram_en,
    input  logic [3:0]           data_sram_wen,
    input  logic [31:0]          data_sram_addr,
    input  logic [31:0]          data_sram_wdata,
    output logic [31:0]          data_sram_rdata,
    output logic                 init_done,
    output logic                 addr_err,
    output logic [CNT_WIDTH-1:0] rd_cnt,
    output logic [CNT_WIDTH-1:0] wr_cnt
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {INIT, READY} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] init_cnt;
    logic [31:0]           mem [DEPTH];

    logic [ADDR_WIDTH-1:0] idx;
    logic                  hi_err;
    logic [1:0]            addr_unused;
    logic                  acc, rd_acc, wr_acc;
    logic                  mem_we;
    logic [3:0]            mem_be;
    logic [ADDR_WIDTH-1:0] mem_idx;
    logic [31:0]           mem_wd;

    // Byte offset is the CPU's concern; upper bits alias but are flagged.
    assign idx         = data_sram_addr[ADDR_WIDTH+1:2];
    assign hi_err      = |data_sram_addr[31:ADDR_WIDTH+2];
    assign addr_unused = data_sram_addr[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= INIT_EN ? INIT : READY;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state == INIT && init_cnt == LAST_IDX) state_nxt = READY;
    end

    always_comb begin
        acc     = 1'b0;
        rd_acc  = 1'b0;
        wr_acc  = 1'b0;
        mem_we  = 1'b0;
        mem_be  = 4'h0;
        mem_idx = idx;
        mem_wd  = data_sram_wdata;
        if (state == INIT) begin
            mem_we  = 1'b1;
            mem_be  = 4'hF;
            mem_idx = init_cnt;
            mem_wd  = 32'h0;
        end else begin
            acc     = data_sram_en;
            rd_acc  = data_sram_en && (data_sram_wen == 4'h0);
            wr_acc  = data_sram_en && (data_sram_wen != 4'h0);
            mem_we  = wr_acc;
            mem_be  = data_sram_wen;
        end
    end

    // Array has no reset; the init sequencer is what makes its contents defined.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_be[b]) mem[mem_idx][8*b +: 8] <= mem_wd[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_cnt        <= '0;
            init_done       <= 1'b0;
            data_sram_rdata <= 32'h0;
            addr_err        <= 1'b0;
            rd_cnt          <= '0;
            wr_cnt          <= '0;
        end else begin
            if (state == INIT) init_cnt <= init_cnt + 1'b1;
            init_done <= (state_nxt == READY);
            // Pre-write word on writes; a following read sees the merged data.
            if (acc) data_sram_rdata <= mem[idx];
            addr_err <= acc && hi_err;
            if (rd_acc && rd_cnt != '1) rd_cnt <= rd_cnt + 1'b1;
            if (wr_acc && wr_cnt != '1) wr_cnt <= wr_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_data_sram_responder.sv
// Randomized and directed bench for data_sram_responder against a word-array model.
module tb_data_sram_responder;
    localparam int AW    = 4;
    localparam int CW    = 2;
    localparam int DEPTH = 16;
    localparam int CMAX  = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [3:0]    wen;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic          init_done;
    logic          addr_err;
    logic [CW-1:0] rd_cnt;
    logic [CW-1:0] wr_cnt;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem_m [DEPTH];
    int          init_m;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_done;
    int          exp_rd;
    int          exp_wr;

    always #5 clk = ~clk;

    data_sram_responder #(.ADDR_WIDTH(AW), .INIT_EN(1'b1), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .data_sram_en(en), .data_sram_wen(wen), .data_sram_addr(addr),
        .data_sram_wdata(wdata), .data_sram_rdata(rdata),
        .init_done(init_done), .addr_err(addr_err),
        .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'h0;
        init_m = 0; exp_rdata = 32'h0; exp_err = 1'b0; exp_done = 1'b0;
        exp_rd = 0; exp_wr = 0;
    endtask

    task automatic apply_reset();
        en = 1'b0; wen = 4'h0; addr = 32'h0; wdata = 32'h0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
    endtask

    // One clock with the given request; the model advances alongside.
    task automatic do_cyc(input logic e, input logic [3:0] w, input logic [31:0] a,
                          input logic [31:0] d);
        int i;
        en = e; wen = w; addr = a; wdata = d;
        exp_err = 1'b0;
        if (init_m == DEPTH) begin
            if (e) begin
                i = int'(a / 4) % DEPTH;
                exp_rdata = mem_m[i];
                exp_err = (a / (4 * DEPTH)) != 0;
                if (w == 4'h0) begin
                    if (exp_rd < CMAX) exp_rd++;
                end else begin
                    for (int b = 0; b < 4; b++)
                        if (w[b]) mem_m[i][8*b +: 8] = d[8*b +: 8];
                    if (exp_wr < CMAX) exp_wr++;
                end
            end
        end else begin
            init_m++;
        end
        exp_done = (init_m == DEPTH);
        step();
        en = 1'b0; wen = 4'h0;
    endtask

    task automatic finish_init();
        while (init_m < DEPTH) do_cyc(1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (rdata !== 32'h0 || init_done !== 1'b0 || addr_err !== 1'b0 ||
            rd_cnt !== '0 || wr_cnt !== '0) begin
            errors++;
            $display("FAIL reset_state: rdata=%h done=%b err=%b rd=%0d wr=%0d required all zero",
                     rdata, init_done, addr_err, rd_cnt, wr_cnt);
        end
        for (int k = 1; k <= DEPTH + 2; k++) begin
            do_cyc(1'b0, 4'h0, 32'h0, 32'h0);
            checks++;
            if (init_done !== (k >= DEPTH)) begin
                errors++;
                $display("FAIL init_done_timing: cycle %0d got %b required %b",
                         k, init_done, k >= DEPTH);
            end
        end
        do_cyc(1'b1, 4'h0, 32'h0000_0024, 32'h0);
        checks++;
        if (rdata !== 32'h0) begin
            errors++;
            $display("FAIL read_after_clear: got %h required 00000000", rdata);
        end
    endtask

    task automatic test_write_read();
        apply_reset();
        finish_init();
        do_cyc(1'b1, 4'hF, 32'h8, 32'hDEADBEEF);
        do_cyc(1'b1, 4'h0, 32'h8, 32'h0);
        checks++;
        if (rdata !== 32'hDEADBEEF || rd_cnt !== 2'd1 || wr_cnt !== 2'd1) begin
            errors++;
            $display("FAIL write_read: rdata=%h rd=%0d wr=%0d required deadbeef 1 1",
                     rdata, rd_cnt, wr_cnt);
        end
    endtask

    task automatic test_byte_lanes();
        do_cyc(1'b1, 4'hF, 32'h4, 32'h11223344);
        do_cyc(1'b1, 4'b0101, 32'h4, 32'hAABBCCDD);
        checks++;
        if (rdata !== 32'h11223344) begin
            errors++;
            $display("FAIL read_before_write: got %h required 11223344", rdata);
        end
        do_cyc(1'b1, 4'h0, 32'h7, 32'h0);
        checks++;
        if (rdata !== 32'h11BB33DD) begin
            errors++;
            $display("FAIL byte_merge: got %h required 11bb33dd", rdata);
        end
    endtask

    task automatic test_alias();
        do_cyc(1'b1, 4'hF, 32'h40, 32'h55);
        checks++;
        if (addr_err !== 1'b1) begin
            errors++;
            $display("FAIL addr_err_pulse: got %b required 1", addr_err);
        end
        do_cyc(1'b0, 4'h0, 32'h0, 32'h0);
        checks++;
        if (addr_err !== 1'b0) begin
            errors++;
            $display("FAIL addr_err_clear: got %b required 0", addr_err);
        end
        do_cyc(1'b1, 4'h0, 32'h0, 32'h0);
        checks++;
        if (rdata !== 32'h55 || addr_err !== 1'b0) begin
            errors++;
            $display("FAIL alias_read: rdata=%h err=%b required 00000055 0", rdata, addr_err);
        end
    endtask

    task automatic test_init_block_and_hold();
        apply_reset();
        do_cyc(1'b1, 4'hF, 32'h0, 32'hFFFFFFFF);
        finish_init();
        checks++;
        if (rd_cnt !== '0 || wr_cnt !== '0 || rdata !== 32'h0) begin
            errors++;
            $display("FAIL init_ignores_req: rd=%0d wr=%0d rdata=%h required 0 0 0",
                     rd_cnt, wr_cnt, rdata);
        end
        do_cyc(1'b0, 4'hF, 32'h0, 32'hCAFEF00D);
        do_cyc(1'b1, 4'h0, 32'h0, 32'h0);
        checks++;
        if (rdata !== 32'h0 || wr_cnt !== '0) begin
            errors++;
            $display("FAIL blocked_write: rdata=%h wr=%0d required 00000000 0", rdata, wr_cnt);
        end
        do_cyc(1'b1, 4'hF, 32'hC, 32'h1234);
        do_cyc(1'b1, 4'h0, 32'hC, 32'h0);
        for (int k = 0; k < 5; k++) begin
            do_cyc(1'b0, 4'h0, 32'h0, 32'h0);
            checks++;
            if (rdata !== 32'h1234) begin
                errors++;
                $display("FAIL idle_hold: cycle %0d got %h required 00001234", k, rdata);
            end
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        finish_init();
        for (int k = 0; k < 5; k++) do_cyc(1'b1, 4'h0, 32'(k * 4), 32'h0);
        checks++;
        if (rd_cnt !== 2'd3 || wr_cnt !== 2'd0) begin
            errors++;
            $display("FAIL rd_saturate: rd=%0d wr=%0d required 3 0", rd_cnt, wr_cnt);
        end
        for (int k = 0; k < 5; k++) do_cyc(1'b1, 4'h1, 32'(k * 4), 32'hFF);
        checks++;
        if (wr_cnt !== 2'd3) begin
            errors++;
            $display("FAIL wr_saturate: got %0d required 3", wr_cnt);
        end
        apply_reset();
        for (int k = 0; k < 5; k++) do_cyc(1'b0, 4'h0, 32'h0, 32'h0);
        apply_reset();
        checks++;
        if (rd_cnt !== '0 || init_done !== 1'b0) begin
            errors++;
            $display("FAIL mid_init_reset: rd=%0d done=%b required 0 0", rd_cnt, init_done);
        end
        for (int k = 1; k <= DEPTH; k++) begin
            do_cyc(1'b0, 4'h0, 32'h0, 32'h0);
            checks++;
            if (init_done !== (k == DEPTH)) begin
                errors++;
                $display("FAIL reinit_timing: cycle %0d got %b required %b",
                         k, init_done, k == DEPTH);
            end
        end
    endtask

    task automatic test_back_to_back_random();
        logic [31:0] a;
        apply_reset();
        finish_init();
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 199) == 0) apply_reset();
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a = a % (4 * DEPTH);
            do_cyc($urandom_range(0, 3) != 0,
                   ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom), a, $urandom);
            checks++;
            if (rdata !== exp_rdata || addr_err !== exp_err || init_done !== exp_done ||
                rd_cnt !== CW'(exp_rd) || wr_cnt !== CW'(exp_wr)) begin
                errors++;
                $display("FAIL random_%0d: rdata=%h err=%b done=%b rd=%0d wr=%0d required %h %b %b %0d %0d",
                         k, rdata, addr_err, init_done, rd_cnt, wr_cnt,
                         exp_rdata, exp_err, exp_done, exp_rd, exp_wr);
            end
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; wen = 4'h0; addr = 32'h0; wdata = 32'h0;
        model_reset();
        step();
        test_reset();
        test_write_read();
        test_byte_lanes();
        test_alias();
        test_init_block_and_hold();
        test_saturation();
        test_back_to_back_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
